// File: rtl/riscv_enc_pkg.sv
// -----------------------------------------------------------------------------
// riscv_enc_pkg
// Shared definitions for the RV64I instruction encoder:
//   - base opcode constants for the supported formats
//   - instruction format enum and encoder state enum
//   - immediate range limits used by the optional range check
//   - fmt_of(): opcode -> format classification
// Optional feature macro used by the consumers of this package: RANGE_CHECK_EN.
// -----------------------------------------------------------------------------
package riscv_enc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_SB,
    FMT_BAD
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_HOLD,
    ST_FULL
  } state_e;

  // 12-bit signed immediate (I and S formats)
  localparam logic signed [63:0] IMM12_MIN = -64'sd2048;
  localparam logic signed [63:0] IMM12_MAX = 64'sd2047;
  // 13-bit signed, even branch offset (SB format)
  localparam logic signed [63:0] IMM13_MIN = -64'sd4096;
  localparam logic signed [63:0] IMM13_MAX = 64'sd4094;

  function automatic fmt_e fmt_of(input logic [6:0] opcode);
    fmt_e f;
    case (opcode)
      OP_R:                     f = FMT_R;
      OP_LOAD, OP_IMM, OP_JALR: f = FMT_I;
      OP_STORE:                 f = FMT_S;
      OP_BRANCH:                f = FMT_SB;
      default:                  f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// -----------------------------------------------------------------------------
// instr_field_pack
// Purely combinational: packs decoded instruction fields into a 32-bit word.
// Ports:
//   opcode, rd, rs1, rs2, funct3, funct7, imm  - decoded fields (imm signed)
//   fmt       - format selected by the opcode (FMT_BAD for unknown opcodes)
//   word      - packed instruction word (zero for FMT_BAD)
//   range_ok  - immediate is encodable for the format
// Macro RANGE_CHECK_EN: when defined, out-of-range or odd branch immediates
// clear range_ok; otherwise the immediate is truncated and range_ok stays 1.
// -----------------------------------------------------------------------------
module instr_field_pack
  import riscv_enc_pkg::*;
(
  input  logic [6:0]         opcode,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic signed [63:0] imm,
  output fmt_e               fmt,
  output logic [31:0]        word,
  output logic               range_ok
);

`ifdef RANGE_CHECK_EN
  function automatic logic fits_imm12(input logic signed [63:0] v);
    return (v >= IMM12_MIN) && (v <= IMM12_MAX);
  endfunction

  function automatic logic fits_branch(input logic signed [63:0] v);
    return (v >= IMM13_MIN) && (v <= IMM13_MAX) && !v[0];
  endfunction
`else
  // Upper immediate bits only matter for the range check.
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[63:13];
`endif

  always_comb begin
    fmt      = fmt_of(opcode);
    word     = '0;
    range_ok = 1'b1;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        word = {imm[11:0], rs1, funct3, rd, opcode};
`ifdef RANGE_CHECK_EN
        range_ok = fits_imm12(imm);
`endif
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
`ifdef RANGE_CHECK_EN
        range_ok = fits_imm12(imm);
`endif
      end
      FMT_SB: begin
        // imm[0] has no slot in the branch encoding.
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
`ifdef RANGE_CHECK_EN
        range_ok = fits_branch(imm);
`endif
      end
      default: range_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// -----------------------------------------------------------------------------
// instruction_encoder
// Encodes RV64I field bundles into 32-bit instruction words and streams them
// to instruction memory at consecutive word addresses starting at BASE_ADDR.
// Parameters: DEPTH (words before full), BASE_ADDR (byte address of word 0).
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready + opcode, rd, rs1, rs2, funct3, funct7, imm : input side
//   clear      - synchronous restart of counter, error flag and state
//   out_valid/out_ready + out_data, out_addr : memory write side
//   full       - DEPTH words written; only clear or reset leave this state
//   err        - sticky, a bundle was rejected
//   count      - words written so far
// Macro RANGE_CHECK_EN: reject immediates that do not fit their format.
// -----------------------------------------------------------------------------
module instruction_encoder
  import riscv_enc_pkg::*;
#(
  parameter  int          DEPTH     = 64,
  parameter  logic [63:0] BASE_ADDR = 64'd0,
  localparam int          CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         opcode,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic signed [63:0] imm,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [63:0]        out_addr,
  output logic               full,
  output logic               err,
  output logic [CNT_W-1:0]   count
);

  fmt_e             pk_fmt;
  logic [31:0]      pk_word;
  logic             pk_ok;

  state_e           state_q, state_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic [CNT_W:0]   pending;
  logic             accept;
  logic             good;
  logic             out_hs;

  instr_field_pack u_pack (
    .opcode   (opcode),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .funct3   (funct3),
    .funct7   (funct7),
    .imm      (imm),
    .fmt      (pk_fmt),
    .word     (pk_word),
    .range_ok (pk_ok)
  );

  assign out_valid = (state_q == ST_HOLD);
  assign full      = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign err       = err_q;
  assign count     = count_q;
  assign out_addr  = BASE_ADDR + (64'(count_q) << 2);

  // Words written plus the one in flight; no accept may push this past DEPTH.
  assign pending  = {1'b0, count_q} + (CNT_W + 1)'(out_valid);
  assign in_ready = (state_q != ST_FULL) && (!out_valid || out_ready)
                    && (pending < (CNT_W + 1)'(DEPTH));

  assign accept = in_valid && in_ready;
  assign good   = accept && (pk_fmt != FMT_BAD) && pk_ok;
  assign out_hs = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    err_d   = err_q;
    if (clear) begin
      // A bundle accepted together with clear is dropped.
      state_d = ST_EMPTY;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (out_hs)          count_d = count_q + CNT_W'(1);
      if (accept && !good) err_d   = 1'b1;
      if (good)            data_d  = pk_word;
      case (state_q)
        ST_EMPTY: if (good) state_d = ST_HOLD;
        ST_HOLD: begin
          // A good accept in HOLD implies out_ready, so the old word leaves
          // on the same edge and the new one replaces it.
          if (good)        state_d = ST_HOLD;
          else if (out_hs) state_d = (count_d == CNT_W'(DEPTH)) ? ST_FULL : ST_EMPTY;
        end
        ST_FULL:  state_d = ST_FULL;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule
